// File: rtl/direct_mapped_cache_ram.sv
// Direct-mapped, write-through / no-write-allocate cache in front of a multi-cycle backing RAM.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module direct_mapped_cache_ram #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned NUM_LINES   = 8,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
`ifdef CACHE_STATS_EN
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count,
`endif
    input  logic                  flush
);

    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int unsigned LINE_AW = OFF_W + IDX_W;
    localparam int unsigned CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = {OFF_W{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFill,
        StWrite,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    hit_q, hit_d;
    logic [CNT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic [OFF_W-1:0]        word_cnt_q, word_cnt_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_hit_q, resp_hit_d;
`ifdef CACHE_STATS_EN
    logic [15:0]             hit_count_q, hit_count_d;
    logic [15:0]             miss_count_q, miss_count_d;
`endif

    // Storage arrays are deliberately left out of reset.
    logic [DATA_WIDTH-1:0]   mem_q        [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   cache_data_q [2**LINE_AW];
    logic [TAG_W-1:0]        tag_store_q  [NUM_LINES];

    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [LINE_AW-1:0]      req_line_word;
    logic [ADDR_WIDTH-1:0]   fill_addr;
    logic                    lookup_hit;
    logic                    lat_done;
    logic                    fill_we;
    logic                    mem_we;
    logic                    cache_we;
    logic                    tag_we;

    assign req_idx       = addr_q[OFF_W +: IDX_W];
    assign req_tag       = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign req_line_word = addr_q[LINE_AW-1:0];
    assign fill_addr     = {req_tag, req_idx, word_cnt_q};
    assign lookup_hit    = valid_q[req_idx] && (tag_store_q[req_idx] == req_tag);
    assign lat_done      = (lat_cnt_q == LAT_LAST);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        hit_d        = hit_q;
        lat_cnt_d    = lat_cnt_q;
        word_cnt_d   = word_cnt_q;
        valid_d      = valid_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        fill_we      = 1'b0;
        mem_we       = 1'b0;
        cache_we     = 1'b0;
        tag_we       = 1'b0;
`ifdef CACHE_STATS_EN
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`endif

        unique case (state_q)
            StIdle: begin
                // Flush wins over a simultaneous request.
                if (flush) begin
                    valid_d = '0;
`ifdef CACHE_STATS_EN
                    hit_count_d  = '0;
                    miss_count_d = '0;
`endif
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                hit_d      = lookup_hit;
                lat_cnt_d  = '0;
                word_cnt_d = '0;
                if (we_q) begin
                    state_d = StWrite;
                end else if (lookup_hit) begin
                    state_d = StResp;
                end else begin
                    // Line is half-overwritten during the fill, so drop it up front.
                    valid_d[req_idx] = 1'b0;
                    state_d          = StFill;
                end
            end
            StFill: begin
                if (lat_done) begin
                    lat_cnt_d  = '0;
                    fill_we    = 1'b1;
                    word_cnt_d = word_cnt_q + OFF_W'(1);
                    if (word_cnt_q == OFF_LAST) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        state_d          = StResp;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end
            StWrite: begin
                if (lat_done) begin
                    mem_we   = 1'b1;
                    cache_we = hit_q;
                    state_d  = StResp;
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                resp_valid_d = 1'b1;
                resp_hit_d   = hit_q;
                resp_rdata_d = we_q ? '0 : cache_data_q[req_line_word];
`ifdef CACHE_STATS_EN
                if (hit_q) begin
                    if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
                end else begin
                    if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
                end
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            lat_cnt_q    <= '0;
            word_cnt_q   <= '0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
`ifdef CACHE_STATS_EN
            hit_count_q  <= '0;
            miss_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            hit_q        <= hit_d;
            lat_cnt_q    <= lat_cnt_d;
            word_cnt_q   <= word_cnt_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
`ifdef CACHE_STATS_EN
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
        if (fill_we) begin
            cache_data_q[{req_idx, word_cnt_q}] <= mem_q[fill_addr];
        end
        if (cache_we) begin
            cache_data_q[req_line_word] <= wdata_q;
        end
        if (tag_we) begin
            tag_store_q[req_idx] <= req_tag;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_hit   = resp_hit_q;
`ifdef CACHE_STATS_EN
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_direct_mapped_cache_ram.sv
// Randomised self-checking bench for direct_mapped_cache_ram against a behavioural cache model.
// Stats outputs are connected and checked only when CACHE_STATS_EN is defined.
module tb_direct_mapped_cache_ram;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NL = 8;
    localparam int LW = 4;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          flush = 1'b0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_hit;
`ifdef CACHE_STATS_EN
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
    int            m_hits = 0;
    int            m_miss = 0;
`endif

    direct_mapped_cache_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_LINES  (NL),
        .LINE_WORDS (LW),
        .MEM_LATENCY(ML)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_hit  (resp_hit),
`ifdef CACHE_STATS_EN
        .hit_count (hit_count),
        .miss_count(miss_count),
`endif
        .flush     (flush)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: RAM contents plus per-line valid/tag.
    logic [DW-1:0] m_mem [256];
    bit            m_valid [NL];
    int            m_tag [NL];

    typedef struct {
        int            cyc;
        bit            hit;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    int            acc_cyc = 0;
    int            got_lat = 0;
    logic          got_hit = 1'b0;
    logic [DW-1:0] got_data = '0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_hit = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single compare process for all response-side behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_rdata = '0;
            last_hit   = 1'b0;
        end else begin
            if (q.size() > 0 && cyc < q[0].cyc) check("ready_busy", req_ready, 0);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", resp_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_hit", resp_hit, e.hit);
                    check("resp_rdata", resp_rdata, e.data);
                    got_lat  = cyc - acc_cyc;
                    got_hit  = resp_hit;
                    got_data = resp_rdata;
`ifdef CACHE_STATS_EN
                    check("hit_count", hit_count, m_hits);
                    check("miss_count", miss_count, m_miss);
`endif
                end
                last_rdata = resp_rdata;
                last_hit   = resp_hit;
            end else begin
                check("hold_rdata", resp_rdata, last_rdata);
                check("hold_hit", resp_hit, last_hit);
                if (q.size() > 0 && cyc > q[0].cyc) begin
                    check("resp_missing", resp_valid, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   idx = (int'(a) / LW) % NL;
        int   tg  = int'(a) / (LW * NL);
        int   n   = 0;
        int   lat;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_at_issue", req_ready, 1);
        e.hit = m_valid[idx] && (m_tag[idx] == tg);
        if (we) begin
            e.data   = '0;
            lat      = 2 + ML;
            m_mem[a] = d;
        end else begin
            e.data       = m_mem[a];
            lat          = e.hit ? 2 : 2 + LW * ML;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
`ifdef CACHE_STATS_EN
        if (e.hit) m_hits++;
        else m_miss++;
`endif
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        e.cyc     = cyc + lat;
        q.push_back(e);
        req_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_flush(input bit with_req, input logic [AW-1:0] a);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = with_req;
        req_we    = 1'b0;
        req_addr  = a;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_ready", req_ready, 1);
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
`ifdef CACHE_STATS_EN
        m_hits = 0;
        m_miss = 0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        int            r;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", req_ready, 1);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_rdata", resp_rdata, 0);
        check("reset_hit", resp_hit, 0);

        // Give every RAM word a known value; writes never allocate, so the cache stays cold.
        for (int i = 0; i < 256; i++) do_req(1'b1, AW'(i), DW'($urandom));

        // Cold write, miss-fill read, then hit.
        do_req(1'b1, 8'h13, 8'hA5);
        check("wr13_lat", got_lat, 4);
        check("wr13_hit", got_hit, 0);
        check("wr13_rdata", got_data, 0);
        do_req(1'b0, 8'h13, 8'h00);
        check("rd13_lat", got_lat, 10);
        check("rd13_hit", got_hit, 0);
        check("rd13_rdata", got_data, 8'hA5);
        do_req(1'b0, 8'h13, 8'h00);
        check("rerd13_lat", got_lat, 2);
        check("rerd13_hit", got_hit, 1);
        check("rerd13_rdata", got_data, 8'hA5);

        // Conflict eviction on line index 4.
        do_flush(1'b0, 8'h00);
        do_req(1'b1, 8'h10, 8'h3C);
        do_req(1'b0, 8'h10, 8'h00);
        check("evict_a_hit", got_hit, 0);
        do_req(1'b0, 8'h30, 8'h00);
        check("evict_b_hit", got_hit, 0);
        do_req(1'b0, 8'h10, 8'h00);
        check("evict_c_hit", got_hit, 0);
        check("evict_c_rdata", got_data, 8'h3C);

        // Write hit updates the cached word.
        do_req(1'b0, 8'h20, 8'h00);
        do_req(1'b1, 8'h21, 8'h5A);
        check("wrhit_hit", got_hit, 1);
        do_req(1'b0, 8'h21, 8'h00);
        check("rd21_hit", got_hit, 1);
        check("rd21_rdata", got_data, 8'h5A);

        // Flush beats a simultaneous request.
        do_req(1'b0, 8'h20, 8'h00);
        check("pre_flush_hit", got_hit, 1);
        do_flush(1'b1, 8'h20);
        repeat (4) @(negedge clk);
        do_req(1'b0, 8'h20, 8'h00);
        check("post_flush_hit", got_hit, 0);

        // Reset in the middle of a fill.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h44;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
`ifdef CACHE_STATS_EN
        m_hits = 0;
        m_miss = 0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_fill_ready", req_ready, 1);
        check("rst_fill_rdata", resp_rdata, 0);
        check("rst_fill_hit", resp_hit, 0);
        repeat (12) @(negedge clk);
        do_req(1'b0, 8'h44, 8'h00);
        check("rst_fill_miss", got_hit, 0);

        // Three hits, two misses, then flush.
        do_flush(1'b0, 8'h00);
        do_req(1'b0, 8'h80, 8'h00);
        do_req(1'b0, 8'h80, 8'h00);
        do_req(1'b0, 8'h81, 8'h00);
        do_req(1'b0, 8'h84, 8'h00);
        do_req(1'b0, 8'h85, 8'h00);
`ifdef CACHE_STATS_EN
        check("stats_hits3", hit_count, 3);
        check("stats_miss2", miss_count, 2);
        do_flush(1'b0, 8'h00);
        check("stats_hits_flushed", hit_count, 0);
        check("stats_miss_flushed", miss_count, 0);
`endif

        // Random mix over a few tags so hits, conflicts and flushes all occur.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 255));
            else a = AW'(($urandom_range(0, 1) << 5) | $urandom_range(0, 31));
            if (r == 0) do_flush(1'($urandom_range(0, 1)), a);
            else if (r <= 6) do_req(1'b1, a, DW'($urandom));
            else do_req(1'b0, a, '0);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/direct_mapped_cache_ram.md
DIRECT_MAPPED_CACHE_RAM -- requirements
Module: direct_mapped_cache_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word address width; backing RAM depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NUM_LINES, default 8, number of cache lines (power of 2, >=2).
REQ-004 SHALL have parameter LINE_WORDS, default 4, words per line (power of 2, >=2).
REQ-005 SHALL have parameter MEM_LATENCY, default 2, backing-RAM access cycles per word (>=1).
REQ-006 SHALL have port clk  input  1  clock, rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports req_valid input 1 request present; req_ready output 1 controller can accept a request.
REQ-009 SHALL have ports req_we input 1 (1=write); req_addr input ADDR_WIDTH; req_wdata input DATA_WIDTH.
REQ-010 SHALL have ports resp_valid output 1 one-cycle completion pulse; resp_rdata output DATA_WIDTH read data; resp_hit output 1 request hit the cache.
REQ-011 SHALL have port flush input 1; when asserted, invalidates all lines.

Function
REQ-012 SHALL split req_addr into offset = low log2(LINE_WORDS) bits, index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-013 SHALL implement FSM states IDLE, LOOKUP, FILL, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge with req_valid && req_ready, register addr/we/wdata, and go IDLE->LOOKUP.
REQ-015 LOOKUP SHALL compute hit = valid[index] && tag_store[index]==tag; next state is RESP on a read hit, FILL on a read miss, WRITE on any write.
REQ-016 FILL SHALL read the whole line from backing RAM, words at offsets 0..LINE_WORDS-1 in order, MEM_LATENCY cycles each, then set tag and valid and go to RESP.
REQ-017 WRITE SHALL be write-through, no-write-allocate: update backing RAM after MEM_LATENCY cycles, also update the cached word on hit, leave line state unchanged on miss, then go to RESP.
REQ-018 RESP SHALL pulse resp_valid for exactly one cycle with resp_hit and resp_rdata (requested word on reads, 0 on writes), then return to IDLE.
REQ-019 Latency from accept edge to resp_valid SHALL be: read hit 2 cycles; read miss 2+LINE_WORDS*MEM_LATENCY; write 2+MEM_LATENCY.
REQ-020 resp_rdata and resp_hit SHALL hold their last value when resp_valid is 0.
REQ-021 flush in IDLE SHALL clear all valid bits on that edge and SHALL take priority over a simultaneous req_valid, which is not accepted that cycle; flush outside IDLE SHALL be ignored.
REQ-022 Reads to the same index with a different tag SHALL evict the resident line (direct-mapped replacement).

Reset
REQ-023 Reset SHALL force state IDLE, clear all valid bits, and set req_ready=1 one cycle after release, resp_valid=0, resp_rdata=0, resp_hit=0.
REQ-024 Reset during FILL or WRITE SHALL abort the operation and leave the line invalid; no response SHALL be issued.
REQ-025 Reset SHALL NOT clear backing-RAM or cache data arrays.

Configuration
REQ-026 With macro CACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count (16 bits each, reset 0), incremented one per completed request at RESP by resp_hit, saturating at 16'hFFFF, and cleared by flush.
REQ-027 Without CACHE_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-028 Write 0xA5 to addr 0x13 (cold), then read 0x13 -> write resp_hit=0 at +4 cycles; read resp_hit=0 with 0xA5 at +10 cycles; re-read resp_hit=1 with 0xA5 at +2 cycles.
REQ-029 Read 0x10 then 0x30 (same index, different tag), then 0x10 -> all three miss; third response returns the data stored at 0x10.
REQ-030 Fill the line containing 0x20, write 0x5A to 0x21 -> resp_hit=1; read 0x21 -> hit returning 0x5A.
REQ-031 flush asserted together with req_valid in IDLE -> request not accepted that cycle; the following read of a previously cached address misses.
REQ-032 Reset asserted mid-FILL -> no resp_valid pulse, req_ready=1 after release, and the next read of that address misses.
REQ-033 With CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2; flush -> both counters 0.
